// File: rtl/ca_code_gen.sv
// ca_code_gen
//    GPS C/A code generator for the sat_chan bank. One G1/G2 Gold-code LFSR
//    pair, paced by a code NCO, produces all 36 PRN chips in parallel.
//    ca_seq[n] carries PRN n+1. A seek FSM can move the code to any chip.
//
// Build option:
//    CA_SEEK_EN  defined   : load with load_chip != 0 seeks to that chip (busy high)
//                undefined : load only re-seeds to chip 0; load_chip ignored, busy = 0
//
// Ports:
//    clk        system clock (shared with sat_chan)
//    rst_n      asynchronous active-low reset
//    enable     sample strobe; advances the code NCO in RUN
//    code_freq  code NCO increment (chip_rate/sample_rate * 2^NCO_W)
//    load       one-cycle pulse: restart at chip 0 and seek to load_chip
//    load_chip  seek target, 0..1022 (1023 is treated as 0)
//    ca_seq     current chip of PRN1..PRN36
//    chip_idx   index of the chip currently on ca_seq
//    chip_stb   pulse when the code advances in RUN
//    epoch      pulse when chip_idx wraps 1022->0 in RUN
//    busy       high while seeking
//
// state | meaning
// RUN   | code advances on NCO carry-out
// SEEK  | code steps once per clk until chip_idx reaches target
module ca_code_gen #(
   parameter int NCO_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [NCO_W-1:0] code_freq,
   input  logic             load,
   input  logic [9:0]       load_chip,
   output logic [35:0]      ca_seq,
   output logic [9:0]       chip_idx,
   output logic             chip_stb,
   output logic             epoch,
   output logic             busy
);

   localparam logic [9:0]  LAST_CHIP = 10'd1022;
   localparam logic [10:1] SEED      = '1;

   // G2 tap pairs for PRN1..PRN36
   localparam logic [3:0] TAP_A [36] = '{
      4'd2, 4'd3, 4'd4, 4'd5, 4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd5,
      4'd6, 4'd7, 4'd8, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd1, 4'd4,
      4'd5, 4'd6, 4'd7, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd1, 4'd2};
   localparam logic [3:0] TAP_B [36] = '{
      4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd10, 4'd8, 4'd9, 4'd10, 4'd3, 4'd4, 4'd6,
      4'd7, 4'd8, 4'd9, 4'd10, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd3, 4'd6,
      4'd7, 4'd8, 4'd9, 4'd10, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd10, 4'd7, 4'd8};

   typedef enum logic {RUN, SEEK} state_t;

   state_t           state, nxt_state;
   logic [NCO_W-1:0] phase, phase_n;
   logic [NCO_W:0]   phase_sum;
   logic [10:1]      g1, g2, g1_n, g2_n, g1_step, g2_step;
   logic [9:0]       target, target_n, load_tgt, idx_inc, idx_n;
   logic [35:0]      ca_n;
   logic             wrap, do_step, do_stb, do_reseed, epoch_n;

`ifdef CA_SEEK_EN
   assign load_tgt = (load_chip > LAST_CHIP) ? '0 : load_chip;
`else
   logic unused_load_chip;
   assign unused_load_chip = ^load_chip;
   assign load_tgt         = '0;
`endif

   assign wrap    = (chip_idx == LAST_CHIP);
   assign idx_inc = wrap ? '0 : chip_idx + 10'd1;

   always_comb begin
      nxt_state = state;
      phase_n   = phase;
      target_n  = target;
      do_step   = 1'b0;
      do_stb    = 1'b0;
      do_reseed = 1'b0;
      phase_sum = {1'b0, phase} + {1'b0, code_freq};
      if (load) begin
         do_reseed = 1'b1;
         phase_n   = '0;
         target_n  = load_tgt;
         nxt_state = (load_tgt == '0) ? RUN : SEEK;
      end else begin
         case (state)
            RUN: begin
               if (enable) begin
                  phase_n = phase_sum[NCO_W-1:0];
                  if (phase_sum[NCO_W]) begin
                     do_step = 1'b1;
                     do_stb  = 1'b1;
                  end
               end
            end
            SEEK: begin
               do_step = 1'b1;
               if (idx_inc == target) nxt_state = RUN;
            end
            default: nxt_state = RUN;
         endcase
      end
   end

   // Stepping from the last chip re-seeds instead of shifting so the epoch
   // boundary is exact regardless of LFSR history.
   always_comb begin
      g1_step = wrap ? SEED : {g1[9:1], g1[3] ^ g1[10]};
      g2_step = wrap ? SEED : {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
      g1_n    = g1;
      g2_n    = g2;
      idx_n   = chip_idx;
      if (do_reseed) begin
         g1_n  = SEED;
         g2_n  = SEED;
         idx_n = '0;
      end else if (do_step) begin
         g1_n  = g1_step;
         g2_n  = g2_step;
         idx_n = idx_inc;
      end
      epoch_n = do_stb & wrap;
   end

   // ca_seq is built from the next LFSR state so it stays aligned with chip_idx.
   always_comb begin
      ca_n = '0;
      for (int n = 0; n < 36; n++)
         ca_n[n] = g1_n[10] ^ g2_n[TAP_A[n]] ^ g2_n[TAP_B[n]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         phase    <= '0;
         target   <= '0;
         g1       <= SEED;
         g2       <= SEED;
         chip_idx <= '0;
         ca_seq   <= '1;
         chip_stb <= 1'b0;
         epoch    <= 1'b0;
      end else begin
         state    <= nxt_state;
         phase    <= phase_n;
         target   <= target_n;
         g1       <= g1_n;
         g2       <= g2_n;
         chip_idx <= idx_n;
         ca_seq   <= ca_n;
         chip_stb <= do_stb;
         epoch    <= epoch_n;
      end
   end

`ifdef CA_SEEK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= 1'b0;
      else        busy <= (nxt_state == SEEK);
   end
`else
   assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ca_code_gen.sv
module tb_ca_code_gen;

   logic        clk = 1'b0;
   logic        rst_n, enable, load;
   logic [31:0] code_freq;
   logic [9:0]  load_chip;
   logic [35:0] ca_seq;
   logic [9:0]  chip_idx;
   logic        chip_stb, epoch, busy;

   int vecs = 0;
   int errs = 0;

`ifdef CA_SEEK_EN
   localparam bit SEEK_EN = 1'b1;
`else
   localparam bit SEEK_EN = 1'b0;
`endif

   ca_code_gen #(.NCO_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .code_freq(code_freq),
      .load(load), .load_chip(load_chip), .ca_seq(ca_seq), .chip_idx(chip_idx),
      .chip_stb(chip_stb), .epoch(epoch), .busy(busy));

   always #5 clk = ~clk;

   // Reference: G1/G2 output bit sequences from their recurrences.
   // Stage j of a register at time t equals output bit t+10-j.
   bit s_seq [0:1040];
   bit u_seq [0:1040];
   int ta [36] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4,5,4,1,2};
   int tb [36] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9,10,10,7,8};

   int          m_idx, m_tgt;
   logic [31:0] m_phase;
   bit          m_stb, m_ep, m_busy;

   task automatic build_ref();
      for (int t = 0; t < 10; t++) begin
         s_seq[t] = 1'b1;
         u_seq[t] = 1'b1;
      end
      for (int t = 0; t + 10 <= 1040; t++) begin
         s_seq[t+10] = s_seq[t+7] ^ s_seq[t];
         u_seq[t+10] = u_seq[t+8] ^ u_seq[t+7] ^ u_seq[t+4] ^ u_seq[t+2] ^ u_seq[t+1] ^ u_seq[t];
      end
   endtask

   function automatic logic [35:0] exp_ca(int k);
      logic [35:0] r;
      for (int n = 0; n < 36; n++)
         r[n] = s_seq[k] ^ u_seq[k + 10 - ta[n]] ^ u_seq[k + 10 - tb[n]];
      return r;
   endfunction

   function automatic logic [48:0] exp_vec();
      return {exp_ca(m_idx), 10'(m_idx), m_stb, m_ep, m_busy};
   endfunction

   task automatic model_reset();
      m_idx = 0; m_tgt = 0; m_phase = '0;
      m_stb = 1'b0; m_ep = 1'b0; m_busy = 1'b0;
   endtask

   // Advance the model with the inputs presented now, then let the DUT take the edge.
   task automatic tick();
      logic [32:0] sum;
      m_stb = 1'b0;
      m_ep  = 1'b0;
      if (load) begin
         m_idx   = 0;
         m_phase = '0;
         m_tgt   = (load_chip >= 10'd1023) ? 0 : int'(load_chip);
         m_busy  = SEEK_EN && (m_tgt != 0);
      end else if (m_busy) begin
         m_idx++;
         if (m_idx == m_tgt) m_busy = 1'b0;
      end else if (enable) begin
         sum     = {1'b0, m_phase} + {1'b0, code_freq};
         m_phase = sum[31:0];
         if (sum[32]) begin
            m_stb = 1'b1;
            if (m_idx == 1022) begin
               m_idx = 0;
               m_ep  = 1'b1;
            end else m_idx++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; enable = 1'b0; load = 1'b0; load_chip = '0; code_freq = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++; if (ca_seq !== 36'hF_FFFF_FFFF) begin errs++; $display("FAIL reset_ca_seq got=%h exp=%h", ca_seq, 36'hF_FFFF_FFFF); end
      vecs++; if (chip_idx !== 10'd0) begin errs++; $display("FAIL reset_chip_idx got=%0d exp=0", chip_idx); end
      vecs++; if (chip_stb !== 1'b0) begin errs++; $display("FAIL reset_chip_stb got=%b exp=0", chip_stb); end
      vecs++; if (epoch !== 1'b0) begin errs++; $display("FAIL reset_epoch got=%b exp=0", epoch); end
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
   endtask

   task automatic test_first_chips();
      logic [9:0] p1, p2;
      int strobes, cyc;
      do_reset();
      p1 = {9'd0, ca_seq[0]};
      p2 = {9'd0, ca_seq[1]};
      code_freq = 32'h8000_0000;
      enable    = 1'b1;
      strobes   = 0;
      cyc       = 0;
      while (strobes < 9 && cyc < 40) begin
         tick();
         cyc++;
         vecs++;
         if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
            errs++; $display("FAIL first_chips cyc=%0d got=%h exp=%h", cyc, {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
         end
         if (chip_stb === 1'b1) begin
            strobes++;
            p1 = {p1[8:0], ca_seq[0]};
            p2 = {p2[8:0], ca_seq[1]};
         end
      end
      vecs++; if (cyc !== 18) begin errs++; $display("FAIL stb_period cycles=%0d exp=18", cyc); end
      vecs++; if (p1 !== 10'b1100100000) begin errs++; $display("FAIL prn1_first10 got=%b exp=1100100000", p1); end
      vecs++; if (p2 !== 10'b1110010000) begin errs++; $display("FAIL prn2_first10 got=%b exp=1110010000", p2); end
   endtask

   task automatic test_free_run();
      int n_ep, first_ep, second_ep;
      do_reset();
      code_freq = 32'h8000_0000;
      enable    = 1'b1;
      n_ep = 0; first_ep = -1; second_ep = -1;
      for (int c = 1; c <= 4100; c++) begin
         tick();
         vecs++;
         if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
            errs++; $display("FAIL free_run cyc=%0d got=%h exp=%h", c, {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
         end
         if (epoch === 1'b1) begin
            n_ep++;
            if (n_ep == 1) first_ep = c;
            if (n_ep == 2) second_ep = c;
            vecs++;
            if (chip_idx !== 10'd0 || ca_seq !== 36'hF_FFFF_FFFF || chip_stb !== 1'b1) begin
               errs++; $display("FAIL epoch_state idx=%0d ca=%h stb=%b exp idx=0 ca=fffffffff stb=1", chip_idx, ca_seq, chip_stb);
            end
         end
      end
      vecs++; if (n_ep !== 2) begin errs++; $display("FAIL epoch_count got=%0d exp=2", n_ep); end
      vecs++; if (first_ep !== 2046) begin errs++; $display("FAIL first_epoch cyc=%0d exp=2046", first_ep); end
      vecs++; if (second_ep - first_ep !== 2046) begin errs++; $display("FAIL epoch_gap got=%0d exp=2046", second_ep - first_ep); end
   endtask

   task automatic test_random_run();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) code_freq = $urandom;
         enable = ($urandom_range(0, 3) != 0);
         tick();
         vecs++;
         if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
            errs++; $display("FAIL random_run cyc=%0d got=%h exp=%h", c, {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_seek();
      int busy_cnt, stb_in_busy, cyc;
      do_reset();
      code_freq = 32'hFFFF_FFFF;
      enable    = 1'b1;
      load      = 1'b1;
      load_chip = 10'd10;
      tick();
      load      = 1'b0;
      busy_cnt = 0; stb_in_busy = 0; cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         busy_cnt++;
         if (chip_stb === 1'b1 || epoch === 1'b1) stb_in_busy++;
         vecs++;
         if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
            errs++; $display("FAIL seek cyc=%0d got=%h exp=%h", cyc, {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
         end
         tick();
         cyc++;
      end
      vecs++; if (busy_cnt !== (SEEK_EN ? 10 : 0)) begin errs++; $display("FAIL seek_busy_len got=%0d exp=%0d", busy_cnt, SEEK_EN ? 10 : 0); end
      vecs++; if (stb_in_busy !== 0) begin errs++; $display("FAIL seek_stb got=%0d exp=0", stb_in_busy); end
      vecs++; if (chip_idx !== (SEEK_EN ? 10'd10 : 10'(m_idx))) begin errs++; $display("FAIL seek_end_idx got=%0d exp=%0d", chip_idx, SEEK_EN ? 10 : m_idx); end
      vecs++; if (ca_seq !== exp_ca(SEEK_EN ? 10 : m_idx)) begin errs++; $display("FAIL seek_end_ca got=%h exp=%h", ca_seq, exp_ca(SEEK_EN ? 10 : m_idx)); end
      enable = 1'b0;
   endtask

   task automatic test_load_edge();
      do_reset();
      code_freq = 32'hC000_0000;
      enable    = 1'b1;
      tick();
      load      = 1'b1;
      load_chip = 10'd1023;
      tick();
      load      = 1'b0;
      vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL bad_target_busy got=%b exp=0", busy); end
      vecs++; if (chip_idx !== 10'd0) begin errs++; $display("FAIL bad_target_idx got=%0d exp=0", chip_idx); end
      vecs++; if (chip_stb !== 1'b0) begin errs++; $display("FAIL load_vs_enable_stb got=%b exp=0", chip_stb); end
      tick();
      vecs++; if (chip_stb !== 1'b0) begin errs++; $display("FAIL load_clears_phase stb=%b exp=0", chip_stb); end
      vecs++;
      if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
         errs++; $display("FAIL load_edge got=%h exp=%h", {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
      end
      enable = 1'b0;
   endtask

   task automatic test_reload();
      int busy_cnt, cyc;
      do_reset();
      code_freq = 32'h4000_0000;
      enable    = 1'b1;
      load      = 1'b1;
      load_chip = 10'd900;
      tick();
      load      = 1'b0;
      tick();
      tick();
      load      = 1'b1;
      load_chip = 10'd5;
      tick();
      load      = 1'b0;
      busy_cnt = 0; cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         busy_cnt++;
         tick();
         cyc++;
      end
      vecs++; if (busy_cnt !== (SEEK_EN ? 5 : 0)) begin errs++; $display("FAIL reload_busy_len got=%0d exp=%0d", busy_cnt, SEEK_EN ? 5 : 0); end
      vecs++; if (chip_idx !== (SEEK_EN ? 10'd5 : 10'(m_idx))) begin errs++; $display("FAIL reload_idx got=%0d exp=%0d", chip_idx, SEEK_EN ? 5 : m_idx); end
      vecs++;
      if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
         errs++; $display("FAIL reload got=%h exp=%h", {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid_seek();
      do_reset();
      code_freq = 32'h9000_0000;
      enable    = 1'b1;
      load      = 1'b1;
      load_chip = 10'd500;
      tick();
      load      = 1'b0;
      repeat (7) tick();
      vecs++; if (busy !== SEEK_EN) begin errs++; $display("FAIL mid_seek_busy got=%b exp=%b", busy, SEEK_EN); end
      #2;
      rst_n = 1'b0;
      #1;
      vecs++;
      if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== {36'hF_FFFF_FFFF, 10'd0, 3'b000}) begin
         errs++; $display("FAIL async_reset got=%h exp=%h", {ca_seq, chip_idx, chip_stb, epoch, busy}, {36'hF_FFFF_FFFF, 10'd0, 3'b000});
      end
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      vecs++;
      if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
         errs++; $display("FAIL after_reset got=%h exp=%h", {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
      end
   endtask

   task automatic test_random_loads();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 300 == 0) code_freq = $urandom;
         enable = ($urandom_range(0, 2) != 0);
         load   = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 7) == 0) load_chip = 10'($urandom_range(1000, 1023));
         else                            load_chip = 10'($urandom_range(0, 60));
         tick();
         vecs++;
         if ({ca_seq, chip_idx, chip_stb, epoch, busy} !== exp_vec()) begin
            errs++; $display("FAIL random_loads cyc=%0d got=%h exp=%h", c, {ca_seq, chip_idx, chip_stb, epoch, busy}, exp_vec());
         end
      end
      load   = 1'b0;
      enable = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; load = 1'b0; load_chip = '0; code_freq = '0;
      build_ref();
      model_reset();
      test_reset();
      test_first_chips();
      test_free_run();
      test_random_run();
      test_seek();
      test_load_edge();
      test_reload();
      test_reset_mid_seek();
      test_random_loads();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
